// File: rtl/bias_ram_loader.sv
// Bias RAM write-side loader: fills a contiguous block of bias words from a valid/ready stream.
// Optional running checksum of written words is built only when BIAS_LOAD_CHKSUM_EN is defined.
module bias_ram_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load_start,
    input  logic [ADDR_WIDTH-1:0] i_addr_start_b,
    input  logic [7:0]            i_output_layers,
    input  logic                  i_calc_en,
    input  logic [DATA_WIDTH-1:0] i_dat,
    input  logic                  i_dat_vld,
    output logic                  o_dat_rdy,
    output logic                  o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wr_dat,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_chksum
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [7:0]            count;
    logic [7:0]            beat_cnt;
    logic                  accept;
    logic                  start_ok;
    logic                  last;
    logic                  wrap;

    assign accept   = i_dat_vld && o_dat_rdy;
    // calc_en has priority over a simultaneous start request
    assign start_ok = (state == IDLE) && i_load_start && !i_calc_en;
    assign last     = (beat_cnt == count - 8'd1);
    assign wrap     = (int'(i_addr_start_b) + int'(i_output_layers)) > DEPTH;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = (i_output_layers == 8'd0) ? DONE : LOAD;
            LOAD: begin
                if (i_calc_en)           state_nxt = IDLE;
                else if (accept && last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_dat_rdy = (state == LOAD);
        o_busy    = (state != IDLE);
        o_done    = (state == DONE) && !i_calc_en;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            start_addr   <= '0;
            count        <= '0;
            beat_cnt     <= '0;
            o_ram_wr_en  <= 1'b0;
            o_ram_addr   <= '0;
            o_ram_wr_dat <= '0;
            o_err        <= 1'b0;
        end else begin
            o_ram_wr_en <= accept;
            if (accept) begin
                o_ram_addr   <= start_addr + ADDR_WIDTH'(beat_cnt);
                o_ram_wr_dat <= i_dat;
                if (!last) beat_cnt <= beat_cnt + 8'd1;
            end
            if (start_ok) begin
                start_addr <= i_addr_start_b;
                count      <= i_output_layers;
                beat_cnt   <= '0;
                o_err      <= wrap;
            end else if (i_calc_en && state != IDLE) begin
                o_err <= 1'b1;
            end
        end
    end

`ifdef BIAS_LOAD_CHKSUM_EN
    // Accumulates on acceptance so the sum lands together with the write strobe
    always_ff @(posedge i_clk) begin
        if (i_rst || start_ok) o_chksum <= '0;
        else if (accept)       o_chksum <= o_chksum + i_dat;
    end
`else
    assign o_chksum = '0;
`endif

endmodule

// File: tb/tb_bias_ram_loader.sv
// Self-checking bench for bias_ram_loader: directed loads from the plan plus random loads
// compared each cycle against a transaction-level reference model.
module tb_bias_ram_loader;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_load_start = 1'b0;
    logic [7:0]  i_addr_start_b = '0;
    logic [7:0]  i_output_layers = '0;
    logic        i_calc_en = 1'b0;
    logic [15:0] i_dat = '0;
    logic        i_dat_vld = 1'b0;
    logic        o_dat_rdy, o_ram_wr_en, o_busy, o_done, o_err;
    logic [7:0]  o_ram_addr;
    logic [15:0] o_ram_wr_dat, o_chksum;

    bias_ram_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_load_start(i_load_start),
        .i_addr_start_b(i_addr_start_b), .i_output_layers(i_output_layers),
        .i_calc_en(i_calc_en), .i_dat(i_dat), .i_dat_vld(i_dat_vld),
        .o_dat_rdy(o_dat_rdy), .o_ram_wr_en(o_ram_wr_en), .o_ram_addr(o_ram_addr),
        .o_ram_wr_dat(o_ram_wr_dat), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_chksum(o_chksum)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // reference model: a load in progress with words remaining, a done cycle, a pending write
    bit m_active, m_done, m_wr, m_err;
    int m_rem, m_k, m_start, m_addr, m_dat, m_chk;
    int n_writes;

    task automatic model_reset();
        m_active = 0; m_done = 0; m_wr = 0; m_err = 0;
        m_rem = 0; m_k = 0; m_start = 0; m_addr = 0; m_dat = 0; m_chk = 0;
    endtask

    // one clock cycle: apply inputs, check outputs, advance model across the edge
    task automatic step(input bit st, input int sa, input int lay, input bit ce,
                        input bit vld, input logic [15:0] d, input bit rst);
        bit acc, prev_done;
        i_load_start = st; i_addr_start_b = 8'(sa); i_output_layers = 8'(lay);
        i_calc_en = ce; i_dat_vld = vld; i_dat = d; i_rst = rst;
        #1;
        chk("rdy",  32'(o_dat_rdy),   32'(m_active));
        chk("busy", 32'(o_busy),      32'(m_active || m_done));
        chk("done", 32'(o_done),      32'(m_done && !ce));
        chk("wr",   32'(o_ram_wr_en), 32'(m_wr));
        chk("addr", 32'(o_ram_addr),  32'(m_addr));
        chk("dat",  32'(o_ram_wr_dat), 32'(m_dat));
        chk("err",  32'(o_err),       32'(m_err));
        chk("sum",  32'(o_chksum),    32'(m_chk));
        if (m_wr) n_writes++;
        if (rst) begin
            model_reset();
        end else begin
            acc = vld && m_active;
            m_wr = acc;
            if (acc) begin
                m_addr = (m_start + m_k) % 256;
                m_dat  = int'(d);
`ifdef BIAS_LOAD_CHKSUM_EN
                m_chk  = (m_chk + int'(d)) % 65536;
`endif
                m_k++; m_rem--;
            end
            prev_done = m_done;
            m_done = 0;
            if (m_active) begin
                if (ce) begin m_active = 0; m_err = 1; end
                else if (acc && m_rem == 0) begin m_active = 0; m_done = 1; end
            end else if (prev_done) begin
                if (ce) m_err = 1;
            end else if (st && !ce) begin
                m_err = (sa + lay > 256); m_chk = 0; m_k = 0; m_start = sa;
                if (lay == 0) m_done = 1;
                else begin m_active = 1; m_rem = lay; end
            end
        end
        @(negedge i_clk);
    endtask

    // mode 0: continuous valid, 1: toggling valid, 2: random valid and data
    task automatic do_load(input int sa, input int lay, input int mode,
                           input int abort_at, input int rst_at, input bit busy_start);
        bit vld, ce, r, st;
        logic [15:0] d;
        step(1, sa, lay, 0, 0, 16'h0, 0);
        for (int cyc = 1; cyc < lay * 4 + 8; cyc++) begin
            if (!m_active && !m_done && !m_wr) break;
            ce  = (abort_at >= 0) && m_active && (m_k == abort_at);
            r   = (rst_at >= 0) && m_active && (m_k == rst_at);
            vld = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(cyc % 2) : bit'($urandom_range(0, 1));
            if (ce || r) vld = 0;
            d   = (mode < 2) ? 16'(m_k + 1) : 16'($urandom);
            st  = busy_start && (cyc == 2);
            step(st, st ? 8'h40 : sa, st ? 3 : lay, ce, vld, d, r);
        end
        step(0, 0, 0, 0, 0, 16'h0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge i_clk);
        step(0, 0, 0, 0, 0, 16'h0, 1);
        step(0, 0, 0, 0, 0, 16'h0, 0);

        n_writes = 0;
        do_load(8'h10, 4, 0, -1, -1, 0);
        chk("w_cont", 32'(n_writes), 32'd4);
        n_writes = 0;
        do_load(8'h10, 4, 1, -1, -1, 0);
        chk("w_toggle", 32'(n_writes), 32'd4);
        n_writes = 0;
        do_load(8'hFE, 4, 0, -1, -1, 0);
        chk("w_wrap", 32'(n_writes), 32'd4);
        n_writes = 0;
        do_load(8'h20, 0, 0, -1, -1, 0);
        chk("w_zero", 32'(n_writes), 32'd0);
        n_writes = 0;
        do_load(8'h30, 5, 0, 2, -1, 1);
        chk("w_abort", 32'(n_writes), 32'd2);
        n_writes = 0;
        do_load(8'h50, 8, 0, -1, 3, 0);
        chk("w_reset", 32'(n_writes), 32'd3);
        n_writes = 0;
        do_load(8'h60, 6, 0, -1, -1, 0);
        chk("w_fresh", 32'(n_writes), 32'd6);

        // start coinciding with calc_en in IDLE is dropped
        step(1, 8'h70, 3, 1, 0, 16'h0, 0);
        repeat (2) step(0, 0, 0, 0, 1, 16'h1234, 0);

        for (int i = 0; i < 16; i++) begin
            int sa, lay, ab;
            sa  = (i % 3 == 0) ? int'($urandom_range(240, 255)) : int'($urandom_range(0, 255));
            lay = int'($urandom_range(0, 20));
            ab  = (i % 5 == 4) ? int'($urandom_range(0, 3)) : -1;
            do_load(sa, lay, 2, ab, -1, bit'(i % 4 == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bias_ram_loader.md
# bias_ram_loader

Write-side counterpart of `bias_addr_gen`: accepts a stream of bias words and writes them into the bias RAM. It fills a contiguous block of `i_output_layers` words starting at `i_addr_start_b`, which `bias_addr_gen` later reads back during calculation. It sits between the bias DMA/load path and the bias RAM write port, and is idle whenever a calculation runs.

## Interface
Parameters:
- ADDR_WIDTH, 8, bias RAM address width
- DATA_WIDTH, 16, bias word width

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_load_start  in  1  one-cycle pulse; latches config and starts a load
- i_addr_start_b  in  ADDR_WIDTH  first RAM address of the block
- i_output_layers  in  8  number of bias words to write (0 = none)
- i_calc_en  in  1  calculation start; aborts an active load
- i_dat  in  DATA_WIDTH  bias word
- i_dat_vld  in  1  i_dat valid
- o_dat_rdy  out  1  loader accepts a beat
- o_ram_wr_en  out  1  RAM write strobe
- o_ram_addr  out  ADDR_WIDTH  RAM write address
- o_ram_wr_dat  out  DATA_WIDTH  RAM write data
- o_busy  out  1  load in progress (LOAD or DONE)
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  sticky error flag: wrap or abort
- o_chksum  out  DATA_WIDTH  running sum of written words

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE→LOAD on i_load_start when i_output_layers≠0. Latches the start address and count, clears the beat counter, o_err and o_chksum.
  - IDLE→DONE on i_load_start when i_output_layers=0. No writes occur.
  - LOAD→DONE when a beat is accepted and the counter reaches the latched count minus 1.
  - DONE→IDLE unconditionally after one cycle.
- A beat is accepted when i_dat_vld && o_dat_rdy. o_dat_rdy is 1 only in LOAD.
- Accepted beat k (k = 0..count-1) is written to address (start + k) mod 2^ADDR_WIDTH.
- Wrap: if start + count > 2^ADDR_WIDTH (9-bit compare at start), o_err is set in the cycle after i_load_start. Addresses still wrap modulo 2^ADDR_WIDTH and the load completes normally.
- i_load_start while o_busy is ignored.
- i_calc_en in LOAD or DONE forces the FSM to IDLE next cycle, sets o_err, and suppresses o_done. A write for a beat accepted in the same cycle still issues.
- i_calc_en and i_load_start together in IDLE: i_calc_en wins and the start is dropped.
- Beat counter is 8 bits; it never exceeds count-1.

## Timing
- Reset values: o_dat_rdy=0, o_ram_wr_en=0, o_ram_addr=0, o_ram_wr_dat=0, o_busy=0, o_done=0, o_err=0, o_chksum=0. FSM resets to IDLE. Reset mid-load discards the load; no further writes.
- i_load_start at cycle T → o_dat_rdy=1 and o_busy=1 at T+1.
- Beat accepted at cycle N → o_ram_wr_en=1 with its address and data at N+1, all registered. Back-to-back beats give back-to-back writes.
- Last beat accepted at N → FSM in DONE at N+1. o_done=1 and the last write coincide at N+1; o_dat_rdy=0 from N+1. IDLE at N+2.
- Zero-count start at T → o_done at T+1 with no writes.
- o_err stays set until the next accepted i_load_start.

## Configuration
- BIAS_LOAD_CHKSUM_EN defined: o_chksum accumulates every written word modulo 2^DATA_WIDTH. It updates in the same cycle as the corresponding o_ram_wr_en and holds its value after DONE.
- BIAS_LOAD_CHKSUM_EN undefined: no accumulator is built and o_chksum is tied to 0.

## Test plan
- start=0x10, layers=4, data 1,2,3,4 streamed continuously → writes to 0x10..0x13 on 4 consecutive cycles; o_done with the 0x13 write; o_err=0; o_chksum=10 (0 without macro).
- Same load with i_dat_vld toggling 1,0,1,0 → 4 writes, each exactly one cycle after its acceptance; no write in gap cycles.
- start=0xFE, layers=4 → writes to 0xFE, 0xFF, 0x00, 0x01; o_err=1 from the cycle after start; o_done asserted.
- layers=0 → o_done one cycle after start; no o_ram_wr_en; o_busy high for that single cycle.
- i_calc_en after 2 of 5 beats → exactly 2 writes, FSM in IDLE next cycle, o_err=1, no o_done. A second i_load_start while busy has no effect.
- i_rst after 3 of 8 beats → all outputs 0 next cycle; a fresh load then runs normally.
